wrr_pkt_arbiter: RTL
====================

# wrr_pkt_arbiter

Parametrised N-way weighted round-robin arbiter with packet locking and a ready/valid handshake toward a single shared downstream port. It generalises the 4-way single-cycle round-robin arbiter in three ways:
- Requester count is a parameter.
- A grant is held for a whole multi-beat packet.
- Each requester may win up to a configurable number of consecutive packets before priority rotates.

It sits in front of any shared bus or FIFO write port that multiple masters feed packets into.

## Interface
- `N`, 4: number of requesters, ≥2, need not be a power of two.
- `WEIGHT_W`, 4: width of each per-requester weight field.
- `IDX_W`, `$clog2(N)`: width of the grant index (derived, not overridden).

Ports:
- `clk`  in  1  single clock; all state updates on posedge.
- `rst`  in  1  asynchronous, active-low reset.
- `req`  in  N  per-requester valid; must stay high for every beat of a packet.
- `last`  in  N  per-requester end-of-packet flag; qualified by `req`.
- `weight`  in  N*WEIGHT_W  packets per turn; requester i uses slice `[i*WEIGHT_W +: WEIGHT_W]`, quasi-static; 0 treated as 1.
- `out_ready`  in  1  downstream accepts a beat.
- `out_valid`  out  1  `|(grant & req)`.
- `out_last`  out  1  `|(grant & req & last)`.
- `grant`  out  N  one-hot owner (registered), all-zero when idle.
- `grant_id`  out  IDX_W  binary index of the owner; 0 when idle.
- `req_ready`  out  N  `grant & {N{out_ready}}`; per-requester beat accept.

## Operation
- A transfer happens when `out_valid & out_ready`. An end-of-packet transfer happens when it is a transfer and `out_last` is high.
- State machine `ARB` / `LOCK`. State registers:
  - `ptr` (IDX_W): highest-priority index.
  - `owner` (IDX_W)
  - `pkt_cnt` (WEIGHT_W)
  - `grant`
- `ARB`, no grant:
  - If `req == 0`, stay in `ARB`.
  - Otherwise pick the winner by cyclic search starting at `ptr`: the lowest index ≥ `ptr` with `req` set, else the lowest index < `ptr`.
  - On the next edge: `grant <= onehot(winner)` and go to `LOCK`.
  - If `winner != owner`, `pkt_cnt <= 0`. Then `owner <= winner`.
- `LOCK`:
  - `grant` is held unchanged regardless of `req`, `out_ready` or `req` dropping. No transfer occurs while `req[owner]` is low.
  - An end-of-packet transfer clears `grant` and returns to `ARB` on the same edge.
  - At that edge, with effective weight `w = (weight[owner]==0) ? 1 : weight[owner]`:
    - If `pkt_cnt + 1 < w`: `pkt_cnt++` and `ptr <= owner`, so the owner keeps top priority.
    - Else: `pkt_cnt <= 0` and `ptr <= (owner == N-1) ? 0 : owner + 1`.
- The winner in `ARB` is taken only from requesters with `req` high. If the owner has no further request, the next requester in cyclic order wins and `pkt_cnt` restarts.
- `pkt_cnt` arithmetic is unsigned at WEIGHT_W bits. The compare is done at WEIGHT_W+1 bits so that `pkt_cnt + 1` never wraps.
- `ptr` wrap is explicit and valid for non-power-of-two N. Values ≥ N are never produced.
- Starvation freedom: every requester holding `req` is granted within `(N-1) * (2^WEIGHT_W - 1)` packets.

## Timing
- Reset (async assert, sync release): `grant=0`, `grant_id=0`, `out_valid=0`, `out_last=0`, `req_ready=0`, state `ARB`, `ptr=0`, `owner=0`, `pkt_cnt=0`.
- Arbitration latency: `req` seen in an `ARB` cycle gives `grant` on the following cycle (1 cycle).
- Every packet is followed by exactly one `ARB` bubble cycle. Peak throughput is L/(L+1) for L-beat packets.
- `out_valid`, `out_last` and `req_ready` are combinational from registered `grant` and the inputs. There is no combinational path from `req` to `grant`.
- `out_ready` low in `LOCK`: `grant`, `ptr` and `pkt_cnt` are frozen.
- `weight` changes take effect at the next end-of-packet compare.
- Reset asserted mid-packet: `grant` drops immediately and the packet is abandoned. After release, arbitration restarts from `ptr=0`.

## Structure
- Package `wrr_arb_pkg` holds the state enum (`ARB`, `LOCK`) and a `onehot`/index helper function.
- Sub-module `rr_pick`:
  - Parameter `N`.
  - Inputs: `req`, `ptr`.
  - Outputs: `any`, winner index.
  - Implemented as double masked/unmasked priority encoders, purely combinational.
- The top level holds the FSM, counters and output logic.

## Test plan
- **Single-beat rotation:** N=4, all weights 1, `req=1111`, `last=1111`, `out_ready=1` → `grant_id` sequence 0,1,2,3,0 with one zero-grant cycle between each.
- **Multi-beat lock:** `req=0101`; requester 0 sends 3 beats (`last` on beat 3), requester 2 waiting → `grant=0001` for 3 transfers, then one idle cycle, then `grant=0100`.
- **Backpressure:** `out_ready=0` for 5 cycles mid-packet → `grant` held, `req_ready=0`, `pkt_cnt` unchanged; the packet completes after `out_ready` returns.
- **Weighted round robin:** `weight0=3`, others 1, all requesting single-beat packets → `grant_id` 0,0,0,1,2,3,0,0,0.
- **Non-power-of-two wrap and zero weight:** N=5, `weight4=0`, `req` only from 4 and 0 → alternating 4,0,4,0; `ptr` never exceeds 4.
- **Reset mid-packet:** assert `rst` low during beat 2 → `grant=0` immediately; after release, `req=0010` → `grant=0010` one cycle later.

Source files
------------

// File: rtl/wrr_arb_pkg.sv
// wrr_arb_pkg: FSM state type and grant encoding helper shared by the arbiter files
package wrr_arb_pkg;
  typedef enum logic {ARB, LOCK} state_e;
  function automatic logic [31:0] onehot(input int unsigned idx);
    return 32'd1 << idx;
  endfunction
endpackage

// File: rtl/rr_pick.sv
// rr_pick: cyclic pick of the lowest requester at or above ptr, else the lowest requester overall
module rr_pick #(
  parameter int N = 4,
  localparam int IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic             any,
  output logic [IDX_W-1:0] idx
);
  assign any = |req;
  always_comb begin
    idx = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) idx = IDX_W'(i);
    end
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i] && i >= int'(ptr)) idx = IDX_W'(i);
    end
  end
endmodule

// File: rtl/wrr_pkt_arbiter.sv
// wrr_pkt_arbiter: N-way weighted round-robin arbiter that locks the grant for a whole packet
module wrr_pkt_arbiter
  import wrr_arb_pkg::*;
#(
  parameter int N = 4,
  parameter int WEIGHT_W = 4,
  localparam int IDX_W = $clog2(N)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [N-1:0]          req,
  input  logic [N-1:0]          last,
  input  logic [N*WEIGHT_W-1:0] weight,
  input  logic                  out_ready,
  output logic                  out_valid,
  output logic                  out_last,
  output logic [N-1:0]          grant,
  output logic [IDX_W-1:0]      grant_id,
  output logic [N-1:0]          req_ready
);
  state_e state_q, state_d;
  logic [IDX_W-1:0] ptr_q, ptr_d, owner_q, owner_d, win;
  logic [WEIGHT_W-1:0] pkt_cnt_q, pkt_cnt_d, w_raw, w_eff;
  logic [WEIGHT_W:0] cnt_inc;
  logic [N-1:0] grant_q, grant_d;
  logic any, eop, keep;
  rr_pick #(.N(N)) u_pick (
    .req(req),
    .ptr(ptr_q),
    .any(any),
    .idx(win)
  );
  assign grant = grant_q;
  assign grant_id = (|grant_q) ? owner_q : '0;
  assign out_valid = |(grant_q & req);
  assign out_last = |(grant_q & req & last);
  assign req_ready = grant_q & {N{out_ready}};
  assign eop = out_valid & out_ready & out_last;
  assign w_raw = weight[owner_q*WEIGHT_W +: WEIGHT_W];
  assign w_eff = (w_raw == '0) ? WEIGHT_W'(1) : w_raw;
  // one extra bit so a full-scale count plus one cannot wrap before the compare
  assign cnt_inc = {1'b0, pkt_cnt_q} + (WEIGHT_W + 1)'(1);
  assign keep = cnt_inc < {1'b0, w_eff};
  always_comb begin
    state_d = state_q;
    ptr_d = ptr_q;
    owner_d = owner_q;
    pkt_cnt_d = pkt_cnt_q;
    grant_d = grant_q;
    if (state_q == ARB && any) begin
      state_d = LOCK;
      grant_d = N'(onehot(32'(win)));
      owner_d = win;
      pkt_cnt_d = (win == owner_q) ? pkt_cnt_q : '0;
    end else if (state_q == LOCK && eop) begin
      state_d = ARB;
      grant_d = '0;
      pkt_cnt_d = keep ? cnt_inc[WEIGHT_W-1:0] : '0;
      ptr_d = keep ? owner_q : (owner_q == IDX_W'(N - 1)) ? '0 : owner_q + IDX_W'(1);
    end
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ARB;
      ptr_q <= '0;
      owner_q <= '0;
      pkt_cnt_q <= '0;
      grant_q <= '0;
    end else begin
      state_q <= state_d;
      ptr_q <= ptr_d;
      owner_q <= owner_d;
      pkt_cnt_q <= pkt_cnt_d;
      grant_q <= grant_d;
    end
  end
endmodule
